// File: rtl/core_pkg.sv
// Shared RV32I core constants and the IF/ID pipeline record.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000);
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    // Everything decode needs to know about one fetched instruction
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

    localparam int unsigned IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between the IF stage and imem.
interface fetch_stage_if;
    import core_pkg::*;

    logic [XLEN-1:0] PCF;
    logic            ImemRdy;
    logic [ILEN-1:0] ImemRd;

    modport master (output PCF, input ImemRdy, input ImemRd);
    modport slave  (input PCF, output ImemRdy, output ImemRd);

endinterface

// File: rtl/flopenrc.sv
// Register with synchronous reset, enable and synchronous clear.
module flopenrc #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Clear only takes effect when the register is enabled
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? CLR_VAL : d;
        end
    end

    // State register; reset beats enable and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage RV32I core.
module fetch_stage
    import core_pkg::XLEN;
    import core_pkg::ILEN;
    import core_pkg::if_id_t;
    import core_pkg::IF_ID_W;
#(
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [ILEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrcE,
    input  logic [XLEN-1:0]      PCTargetE,
    fetch_stage_if.master        imem,
    output logic [ILEN-1:0]      InstrD,
    output logic [XLEN-1:0]      PCD,
    output logic [XLEN-1:0]      PCPlus4D,
    output logic                 ValidD,
    output logic                 MisalignD,
    output logic [31:0]          FetchCount
);

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pcplus4: '0,
                                  valid: 1'b0, misalign: 1'b0};

    logic [XLEN-1:0] pcf_q;
    logic [XLEN-1:0] pcplus4f_c;
    logic [XLEN-1:0] pcf_next_c;
    logic            pcf_en_c;

    if_id_t          fetch_c;
    if_id_t          if_id_q;
    logic            ifid_en_c;
    logic            ifid_clr_c;
    logic            capture_c;

    logic [31:0]     fetch_count_q;
    logic [31:0]     fetch_count_d;

    assign pcplus4f_c = pcf_q + XLEN'(4);

    // Next-PC select: a redirect overrides both stall and imem wait
    always_comb begin
        pcf_en_c   = PCSrcE | (~StallF & imem.ImemRdy);
        pcf_next_c = PCSrcE ? PCTargetE : pcplus4f_c;
    end

    flopenrc #(
        .WIDTH   (XLEN),
        .RST_VAL (RESET_PC),
        .CLR_VAL (RESET_PC)
    ) u_pcf (
        .clk   (clk),
        .reset (reset),
        .en    (pcf_en_c),
        .clr   (1'b0),
        .d     (pcf_next_c),
        .q     (pcf_q)
    );

    assign imem.PCF = pcf_q;

    // IF/ID control: flush beats stall; an imem wait inserts a bubble
    always_comb begin
        fetch_c    = '{instr: imem.ImemRd, pc: pcf_q, pcplus4: pcplus4f_c,
                       valid: 1'b1, misalign: |pcf_q[1:0]};
        ifid_en_c  = ~StallD | FlushD;
        ifid_clr_c = FlushD | ~imem.ImemRdy;
        capture_c  = ~StallD & ~FlushD & imem.ImemRdy;
    end

    flopenrc #(
        .WIDTH   (IF_ID_W),
        .RST_VAL (BUBBLE),
        .CLR_VAL (BUBBLE)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en_c),
        .clr   (ifid_clr_c),
        .d     (fetch_c),
        .q     (if_id_q)
    );

    // Fetch counter advances on every real capture into IF/ID
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(capture_c);
    end

    // Fetch counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign InstrD     = if_id_q.instr;
    assign PCD        = if_id_q.pc;
    assign PCPlus4D   = if_id_q.pcplus4;
    assign ValidD     = if_id_q.valid;
    assign MisalignD  = if_id_q.misalign;
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: model PC/IF-ID, queue of expected fetches.
module tb_fetch_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_rdy;
    logic [31:0] InstrD, PCD, PCPlus4D, FetchCount;
    logic        ValidD, MisalignD;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_valid;
    bit          mon_en      = 1'b0;
    bit          pop_pending = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    fetch_stage_if imem_bus();
    assign imem_bus.ImemRdy = imem_rdy;
    assign imem_bus.ImemRd  = tag(imem_bus.PCF);

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem       (imem_bus),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .MisalignD  (MisalignD),
        .FetchCount (FetchCount)
    );

    // One clock: drive inputs, predict, push expected fetch, commit after edge
    task automatic cyc(input logic rst, input logic stf, input logic std, input logic fl,
                       input logic src, input logic [31:0] tgt, input logic rdy);
        logic [31:0] n_pc, n_cnt;
        logic        n_valid, cap;
        sb_t         e;
        reset = rst; StallF = stf; StallD = std; FlushD = fl;
        PCSrcE = src; PCTargetE = tgt; imem_rdy = rdy;
        cap     = !rst && !fl && !std && rdy;
        n_pc    = rst ? 32'h0 : src ? tgt : (stf || !rdy) ? exp_pc : exp_pc + 32'd4;
        n_valid = (rst || fl) ? 1'b0 : std ? exp_valid : rdy;
        n_cnt   = rst ? 32'd0 : exp_cnt + (cap ? 32'd1 : 32'd0);
        e.pc    = exp_pc;
        e.instr = tag(exp_pc);
        @(posedge clk);
        exp_pc    = n_pc;
        exp_valid = n_valid;
        exp_cnt   = n_cnt;
        if (cap) begin
            sb_q.push_back(e);
            pop_pending = 1'b1;
        end
        mon_en = 1'b1;
        #1;
    endtask

    // Scoreboard: compare every cycle against the model, pop on each capture
    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            checks++;
            if (imem_bus.PCF !== exp_pc) begin
                failures++;
                $display("FAIL sb_pcf got=%h exp=%h", imem_bus.PCF, exp_pc);
            end
            checks++;
            if (FetchCount !== exp_cnt) begin
                failures++;
                $display("FAIL sb_count got=%0d exp=%0d", FetchCount, exp_cnt);
            end
            checks++;
            if (ValidD !== exp_valid) begin
                failures++;
                $display("FAIL sb_valid got=%b exp=%b", ValidD, exp_valid);
            end
            if (pop_pending) begin
                pop_pending = 1'b0;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty got=empty exp=entry");
                end else begin
                    e = sb_q.pop_front();
                    if ({InstrD, PCD, PCPlus4D, MisalignD} !==
                        {e.instr, e.pc, e.pc + 32'd4, |e.pc[1:0]}) begin
                        failures++;
                        $display("FAIL sb_fetch got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                                 InstrD, PCD, PCPlus4D, MisalignD,
                                 e.instr, e.pc, e.pc + 32'd4, |e.pc[1:0]);
                    end
                end
            end else if (!exp_valid) begin
                checks++;
                if ({InstrD, PCD, PCPlus4D, MisalignD} !== {32'h0000_0013, 32'h0, 32'h0, 1'b0}) begin
                    failures++;
                    $display("FAIL sb_bubble got=%h/%h/%h/%b exp=00000013/0/0/0",
                             InstrD, PCD, PCPlus4D, MisalignD);
                end
            end
        end
    end

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if ({imem_bus.PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD, FetchCount} !==
            {32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_state got pcf=%h instr=%h pcd=%h v=%b cnt=%0d exp 0/13/0/0/0",
                     imem_bus.PCF, InstrD, PCD, ValidD, FetchCount);
        end
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 32'h0, 1);
            checks++;
            if (imem_bus.PCF !== 32'(4 * (k + 1)) || PCD !== 32'(4 * k) || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL free_run_%0d got pcf=%h pcd=%h v=%b exp pcf=%h pcd=%h v=1",
                         k, imem_bus.PCF, PCD, ValidD, 32'(4 * (k + 1)), 32'(4 * k));
            end
        end
        checks++;
        if (FetchCount !== 32'd4) begin
            failures++;
            $display("FAIL free_run_count got=%0d exp=4", FetchCount);
        end
    endtask

    task automatic test_stall();
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 0, 0, 32'h0, 1);
            checks++;
            if (imem_bus.PCF !== 32'h8 || PCD !== 32'h4 || InstrD !== tag(32'h4) || FetchCount !== 32'd2) begin
                failures++;
                $display("FAIL stall_hold got pcf=%h pcd=%h cnt=%0d exp pcf=8 pcd=4 cnt=2",
                         imem_bus.PCF, PCD, FetchCount);
            end
        end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (imem_bus.PCF !== 32'hC || PCD !== 32'h8 || FetchCount !== 32'd3) begin
            failures++;
            $display("FAIL stall_release got pcf=%h pcd=%h cnt=%0d exp pcf=c pcd=8 cnt=3",
                     imem_bus.PCF, PCD, FetchCount);
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 1, 1, 32'h100, 1);
        checks++;
        if (imem_bus.PCF !== 32'h100 || InstrD !== 32'h0000_0013 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL redirect_flush got pcf=%h instr=%h v=%b exp pcf=100 instr=13 v=0",
                     imem_bus.PCF, InstrD, ValidD);
        end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (PCD !== 32'h100 || InstrD !== tag(32'h100) || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target got pcd=%h instr=%h v=%b exp pcd=100 instr=%h v=1",
                     PCD, InstrD, ValidD, tag(32'h100));
        end
    endtask

    task automatic test_imem_wait();
        cyc(0, 0, 0, 1, 1, 32'h20, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        checks++;
        if (imem_bus.PCF !== 32'h20 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL wait_hold got pcf=%h v=%b exp pcf=20 v=0", imem_bus.PCF, ValidD);
        end
        cyc(0, 0, 0, 0, 1, 32'h40, 0);
        checks++;
        if (imem_bus.PCF !== 32'h40 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL wait_redirect got pcf=%h v=%b exp pcf=40 v=0", imem_bus.PCF, ValidD);
        end
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (PCD !== 32'h40 || ValidD !== 1'b1 || imem_bus.PCF !== 32'h44) begin
            failures++;
            $display("FAIL wait_resume got pcd=%h v=%b pcf=%h exp pcd=40 v=1 pcf=44",
                     PCD, ValidD, imem_bus.PCF);
        end
    endtask

    task automatic test_misalign_wrap();
        cyc(0, 0, 0, 1, 1, 32'h102, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (PCD !== 32'h102 || MisalignD !== 1'b1 || ValidD !== 1'b1 || PCPlus4D !== 32'h106) begin
            failures++;
            $display("FAIL misalign got pcd=%h mis=%b v=%b p4=%h exp pcd=102 mis=1 v=1 p4=106",
                     PCD, MisalignD, ValidD, PCPlus4D);
        end
        cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        checks++;
        if (imem_bus.PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || MisalignD !== 1'b0) begin
            failures++;
            $display("FAIL wrap got pcf=%h pcd=%h p4=%h mis=%b exp pcf=0 pcd=fffffffc p4=0 mis=0",
                     imem_bus.PCF, PCD, PCPlus4D, MisalignD);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 1, 0, 0, 32'h0, 0);
        cyc(1, 1, 1, 0, 0, 32'h0, 0);
        checks++;
        if (imem_bus.PCF !== 32'h0 || ValidD !== 1'b0 || FetchCount !== 32'd0 || InstrD !== 32'h0000_0013) begin
            failures++;
            $display("FAIL reset_mid got pcf=%h v=%b cnt=%0d instr=%h exp 0/0/0/13",
                     imem_bus.PCF, ValidD, FetchCount, InstrD);
        end
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; imem_rdy = 1'b1;
        exp_pc = 32'h0; exp_cnt = 32'h0; exp_valid = 1'b0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_imem_wait();
        test_misalign_wrap();
        test_reset_mid();
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC register, next-PC selection, the instruction-memory fetch handshake, and the decode-side instruction/PC registers.
- Consumes StallF, StallD and FlushD from the hazard unit, and branch/jump redirects (PCSrcE, PCTargetE) from Execute.
- Feeds InstrD/PCD/PCPlus4D to decode; the hazard unit reads its Rs1D/Rs2D from InstrD.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- StallF  in  1  hold PCF (load-use stall).
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  clear IF/ID register to bubble.
- PCSrcE  in  1  taken branch/jump in Execute.
- PCTargetE  in  XLEN  redirect target.
- ImemRdy  in  1  instruction memory returns valid data for PCF this cycle.
- ImemRd  in  32  instruction word for PCF.
- PCF  out  XLEN  fetch address to instruction memory.
- InstrD  out  32  decode instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble).
- MisalignD  out  1  PCD[1:0] != 0; decode raises the exception.
- FetchCount  out  32  count of instructions delivered to decode.

Behaviour:
- Reset (synchronous, wins over everything):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - ValidD=0, MisalignD=0, FetchCount=0.
- PCPlus4F = PCF+4, combinational, wraps mod 2^XLEN (32'hFFFF_FFFC -> 0).
- PCF update, in priority order:
  - reset -> RESET_PC.
  - PCSrcE -> PCTargetE. This overrides StallF and ImemRdy=0.
  - StallF or !ImemRdy -> hold.
  - else -> PCPlus4F.
- A redirect is never lost: a target taken while ImemRdy=0 becomes the new PCF; the pending fetch of the old PC is abandoned.
- IF/ID update, in priority order:
  - reset or FlushD -> bubble: InstrD=NOP_INSTR, ValidD=0, MisalignD=0; PCD and PCPlus4D cleared to 0.
  - StallD -> hold all IF/ID fields, including ValidD.
  - !ImemRdy -> bubble, same as the flush values.
  - else -> capture InstrD=ImemRd, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1, MisalignD=(PCF[1:0]!=0).
- FlushD overrides StallD when both are asserted.
- The hazard unit never asserts StallD with FlushD for the same instruction, but priority is fixed regardless.
- FetchCount increments by 1 on each cycle the IF/ID capture branch is taken. It wraps at 2^32. It does not decrement on flush; it counts fetches, not retirements.
- Latency: an instruction at PCF with ImemRdy=1 and no stall appears on InstrD one cycle later.
- Redirect penalty: PCSrcE in cycle n produces the target instruction on InstrD in cycle n+2, with ImemRdy=1.
- Misaligned PCTargetE is fetched as-is; ImemRd content is don't-care; MisalignD=1 travels with it.
- Reset asserted mid-stall or mid-wait: next cycle is the reset state; all in-flight state is discarded.

Decomposition:
- Shared package core_pkg: XLEN, RESET_PC, NOP_INSTR constants; IF/ID record typedef (instr, pc, pcplus4, valid, misalign).
- One natural sub-module: flopenrc, a parameterised-width register with synchronous reset, enable, and synchronous clear.
  - Instantiated for PCF (clear unused).
  - Instantiated for the IF/ID record (enable = !StallD, clear = FlushD | !ImemRdy when not stalled).
- The next-PC mux stays inline.

Test Plan:
- Reset then 4 cycles free-run with ImemRdy=1, ImemRd=PC-tagged words -> PCF 0,4,8,C,10; InstrD trails by one cycle; ValidD=1 from cycle 2; FetchCount=4.
- StallF=StallD=1 for 2 cycles at PCF=8 -> PCF stays 8; InstrD/PCD=4 held; FetchCount frozen; resumes at C after release.
- PCSrcE=1, PCTargetE=0x100 with FlushD=1 at PCF=0x10 -> next PCF=0x100, InstrD=NOP_INSTR, ValidD=0; instruction at 0x100 on InstrD two cycles after the redirect.
- ImemRdy=0 for 3 cycles at PCF=0x20, with PCSrcE=1 (target 0x40) in the 2nd cycle -> bubbles on InstrD; PCF becomes 0x40 and 0x20 is never delivered.
- PCTargetE=0x102 redirect -> PCD=0x102, MisalignD=1, ValidD=1; PCF=0xFFFF_FFFC free-run -> next PCF=0.
- Reset asserted while StallD=1 and ImemRdy=0 -> next cycle PCF=RESET_PC, ValidD=0, FetchCount=0.
